ll_req_sequencer: RTL and testbench

- Host-facing request queue and response return stage, directly upstream of the linked-list request/response interface FSM.
- Accepts host requests via valid/ready and buffers them in a small FIFO with a sequence tag per request.
- Issues requests to the interface FSM one at a time as single-cycle req_vld pulses, and collects each response by asserting resp_taken.
- Returns responses to the host through a one-entry output register with valid/ready; tag identifies the originating request.

---
 rtl/ll_req_sequencer_pkg.sv | 32 +++
 rtl/ll_req_fifo.sv | 55 +++++
 rtl/ll_req_sequencer.sv | 151 +++++++++++++++
 tb/tb_ll_req_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ll_req_sequencer_pkg.sv
// Shared linked-list types: request/response opcodes, widths
// and the queued request entry.
package ll_req_sequencer_pkg;

  localparam int PTR_WD     = 4;
  localparam int WR_DATA_WD = 8;
  localparam int LL_TAG_WD  = 2;

  typedef enum logic [2:0] {
    ADD_HEAD,
    ADD_TAIL,
    INSERT_AT,
    DELETE_AT,
    READ_AT,
    RETURN_SIZE
  } t_req_types;

  typedef enum logic [1:0] {
    OK,
    DATA,
    SIZE,
    ERROR
  } t_resp_types;

  typedef struct packed {
    t_req_types            rtype;
    logic [PTR_WD-1:0]     pos;
    logic [WR_DATA_WD-1:0] data;
    logic [LL_TAG_WD-1:0]  tag;
  } t_req_entry;

endpackage

// File: rtl/ll_req_fifo.sv
// Synchronous FIFO of request entries with full/empty/count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ll_req_fifo
  import ll_req_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  t_req_entry    i_wdata,
  output t_req_entry    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  t_req_entry    r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push & ~w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop & ~w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/ll_req_sequencer.sv
// Host request queue: issues one request at a time to the
// list interface FSM and returns tagged responses to the host.
module ll_req_sequencer
  import ll_req_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WD = LL_TAG_WD,
  localparam int CNT_WD = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_req_vld,
  output logic                  host_req_rdy,
  input  t_req_types            host_req_type,
  input  logic [PTR_WD-1:0]     host_req_pos,
  input  logic [WR_DATA_WD-1:0] host_req_data,
  output logic                  host_resp_vld,
  input  logic                  host_resp_rdy,
  output t_resp_types           host_resp_type,
  output logic [WR_DATA_WD-1:0] host_resp_data,
  output logic                  host_resp_data_vld,
  output logic [TAG_WD-1:0]     host_resp_tag,
  output logic                  req_vld,
  output t_req_types            req_type,
  output logic [PTR_WD-1:0]     req_pos,
  output logic [WR_DATA_WD-1:0] req_data,
  output logic                  resp_taken,
  input  logic                  intf_ready,
  input  logic                  resp_vld,
  input  t_resp_types           resp_type,
  input  logic [WR_DATA_WD-1:0] resp_data,
  input  logic                  resp_data_vld,
  output logic [CNT_WD-1:0]     fifo_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_SETTLE
  } t_state;

  t_state                r_state;
  t_state                w_next;
  logic [TAG_WD-1:0]     r_tag_cnt;
  logic [TAG_WD-1:0]     r_cur_tag;
  logic                  r_resp_vld;
  t_resp_types           r_resp_type;
  logic [WR_DATA_WD-1:0] r_resp_data;
  logic                  r_resp_dvld;
  logic [TAG_WD-1:0]     r_resp_tag;
  t_req_entry            w_head;
  t_req_entry            w_wentry;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_slot_free;

  assign host_req_rdy = ~w_full & ~reset_n;
  assign w_push       = host_req_vld & host_req_rdy;
  assign w_pop        = (r_state == S_ISSUE) & ~w_empty;
  assign w_slot_free  = ~r_resp_vld | host_resp_rdy;

  assign w_wentry.rtype = host_req_type;
  assign w_wentry.pos   = host_req_pos;
  assign w_wentry.data  = host_req_data;
  assign w_wentry.tag   = LL_TAG_WD'(r_tag_cnt);

  ll_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    w_next     = r_state;
    req_vld    = 1'b0;
    req_type   = t_req_types'('0);
    req_pos    = '0;
    req_data   = '0;
    resp_taken = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (fifo_count != '0 && intf_ready)
          w_next = S_ISSUE;
      end
      S_ISSUE: begin
        req_vld  = 1'b1;
        req_type = w_head.rtype;
        req_pos  = w_head.pos;
        req_data = w_head.data;
        w_next   = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        resp_taken = resp_vld & w_slot_free;
        if (resp_taken) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        // interface resp_vld may still be high here
        if (intf_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state     <= S_IDLE;
      r_tag_cnt   <= '0;
      r_cur_tag   <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_type <= ERROR;
      r_resp_data <= '0;
      r_resp_dvld <= 1'b0;
      r_resp_tag  <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_tag_cnt <= r_tag_cnt + TAG_WD'(1);
      if (r_state == S_ISSUE)
        r_cur_tag <= TAG_WD'(w_head.tag);
      if (resp_taken) begin
        r_resp_vld  <= 1'b1;
        r_resp_type <= resp_type;
        r_resp_data <= resp_data;
        r_resp_dvld <= resp_data_vld;
        r_resp_tag  <= r_cur_tag;
      end else if (host_resp_rdy) begin
        r_resp_vld <= 1'b0;
      end
    end
  end

  assign host_resp_vld      = r_resp_vld;
  assign host_resp_type     = r_resp_type;
  assign host_resp_data     = r_resp_data;
  assign host_resp_data_vld = r_resp_dvld;
  assign host_resp_tag      = r_resp_tag;

  assign busy = (r_state != S_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_ll_req_sequencer.sv
// Directed bench for ll_req_sequencer with a hand-driven
// interface FSM and immediate-assertion checks.
module tb_ll_req_sequencer;
  import ll_req_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b1;
  logic                  host_req_vld = 1'b0;
  logic                  host_req_rdy;
  t_req_types            host_req_type = ADD_HEAD;
  logic [PTR_WD-1:0]     host_req_pos = '0;
  logic [WR_DATA_WD-1:0] host_req_data = '0;
  logic                  host_resp_vld;
  logic                  host_resp_rdy = 1'b0;
  t_resp_types           host_resp_type;
  logic [WR_DATA_WD-1:0] host_resp_data;
  logic                  host_resp_data_vld;
  logic [1:0]            host_resp_tag;
  logic                  req_vld;
  t_req_types            req_type;
  logic [PTR_WD-1:0]     req_pos;
  logic [WR_DATA_WD-1:0] req_data;
  logic                  resp_taken;
  logic                  intf_ready = 1'b0;
  logic                  resp_vld = 1'b0;
  t_resp_types           resp_type = OK;
  logic [WR_DATA_WD-1:0] resp_data = '0;
  logic                  resp_data_vld = 1'b0;
  logic [2:0]            fifo_count;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  ll_req_sequencer dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .host_req_vld       (host_req_vld),
    .host_req_rdy       (host_req_rdy),
    .host_req_type      (host_req_type),
    .host_req_pos       (host_req_pos),
    .host_req_data      (host_req_data),
    .host_resp_vld      (host_resp_vld),
    .host_resp_rdy      (host_resp_rdy),
    .host_resp_type     (host_resp_type),
    .host_resp_data     (host_resp_data),
    .host_resp_data_vld (host_resp_data_vld),
    .host_resp_tag      (host_resp_tag),
    .req_vld            (req_vld),
    .req_type           (req_type),
    .req_pos            (req_pos),
    .req_data           (req_data),
    .resp_taken         (resp_taken),
    .intf_ready         (intf_ready),
    .resp_vld           (resp_vld),
    .resp_type          (resp_type),
    .resp_data          (resp_data),
    .resp_data_vld      (resp_data_vld),
    .fifo_count         (fifo_count),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_hresp_vld"}, host_resp_vld, 0);
    chk({p, "_hresp_type"}, host_resp_type, ERROR);
    chk({p, "_hresp_data"}, host_resp_data, 0);
    chk({p, "_hresp_dvld"}, host_resp_data_vld, 0);
    chk({p, "_hresp_tag"}, host_resp_tag, 0);
    chk({p, "_req_vld"}, req_vld, 0);
    chk({p, "_req_type"}, req_type, 0);
    chk({p, "_req_pos"}, req_pos, 0);
    chk({p, "_req_data"}, req_data, 0);
    chk({p, "_taken"}, resp_taken, 0);
    chk({p, "_count"}, fifo_count, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_rdy"}, host_req_rdy, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    host_req_vld = 1'b0;
    resp_vld = 1'b0;
    resp_data_vld = 1'b0;
    intf_ready = 1'b0;
    host_resp_rdy = 1'b0;
    #1 chk("rdy_in_reset", host_req_rdy, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk_reset("rst");
  endtask

  task automatic push(input t_req_types t,
                      input logic [PTR_WD-1:0] p,
                      input logic [WR_DATA_WD-1:0] d);
    host_req_vld = 1'b1;
    host_req_type = t;
    host_req_pos = p;
    host_req_data = d;
    #1 chk("push_rdy", host_req_rdy, 1);
    @(negedge clk);
    host_req_vld = 1'b0;
  endtask

  task automatic wait_issue(input logic [PTR_WD-1:0] p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_vld !== 1'b1 && n < 10);
    chk("issue_seen", req_vld, 1);
    chk("issue_pos", req_pos, p);
  endtask

  task automatic respond(input logic [WR_DATA_WD-1:0] d,
                         input logic [1:0] tag);
    chk("wait_no_req", req_vld, 0);
    resp_vld = 1'b1;
    resp_type = DATA;
    resp_data = d;
    resp_data_vld = 1'b1;
    #1 chk("taken", resp_taken, 1);
    @(negedge clk);
    resp_vld = 1'b0;
    resp_data_vld = 1'b0;
    chk("hresp_vld", host_resp_vld, 1);
    chk("hresp_data", host_resp_data, d);
    chk("hresp_tag", host_resp_tag, tag);
  endtask

  task automatic serve(input logic [PTR_WD-1:0] p,
                       input logic [WR_DATA_WD-1:0] d,
                       input logic [1:0] tag);
    wait_issue(p);
    @(negedge clk);
    respond(d, tag);
  endtask

  initial begin
    // single RETURN_SIZE round trip, sticky resp_vld
    do_reset();
    intf_ready = 1'b1;
    push(RETURN_SIZE, 0, 0);
    chk("t1_count", fifo_count, 1);
    chk("t1_idle_noreq", req_vld, 0);
    @(negedge clk);
    chk("t1_issue", req_vld, 1);
    chk("t1_issue_type", req_type, RETURN_SIZE);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_pulse_end", req_vld, 0);
    chk("t1_popped", fifo_count, 0);
    intf_ready = 1'b0;
    resp_vld = 1'b1;
    resp_type = SIZE;
    resp_data = 8'd3;
    resp_data_vld = 1'b1;
    #1 chk("t1_taken", resp_taken, 1);
    @(negedge clk);
    chk("t1_hvld", host_resp_vld, 1);
    chk("t1_htype", host_resp_type, SIZE);
    chk("t1_hdata", host_resp_data, 3);
    chk("t1_hdvld", host_resp_data_vld, 1);
    chk("t1_htag", host_resp_tag, 0);
    host_resp_rdy = 1'b1;
    #1 chk("t1_settle_ignore", resp_taken, 0);
    @(negedge clk);
    chk("t1_single_capture", host_resp_vld, 0);
    chk("t1_settle_busy", busy, 1);
    resp_vld = 1'b0;
    resp_data_vld = 1'b0;
    @(negedge clk);
    chk("t1_settle_hold", busy, 1);
    intf_ready = 1'b1;
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // fill FIFO, stall 5th push, tag wrap
    do_reset();
    host_resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++)
      push(READ_AT, PTR_WD'(i + 1), 8'(8'h10 + i));
    host_req_vld = 1'b1;
    host_req_pos = 5;
    host_req_data = 8'h14;
    #1 chk("t2_full_count", fifo_count, 4);
    chk("t2_full_rdy", host_req_rdy, 0);
    @(negedge clk);
    chk("t2_stall", fifo_count, 4);
    intf_ready = 1'b1;
    @(negedge clk);
    chk("t2_issue1", req_vld, 1);
    chk("t2_issue1_pos", req_pos, 1);
    chk("t2_issue_full_rdy", host_req_rdy, 0);
    chk("t2_issue_count", fifo_count, 4);
    @(negedge clk);
    chk("t2_after_pop", fifo_count, 3);
    chk("t2_rdy_open", host_req_rdy, 1);
    respond(8'hA0, 0);
    host_req_vld = 1'b0;
    chk("t2_fifth_in", fifo_count, 4);
    for (int k = 1; k <= 4; k++)
      serve(PTR_WD'(k + 1), 8'(8'hA0 + k), 2'(k % 4));

    // output backpressure, same-cycle handoff
    do_reset();
    push(INSERT_AT, 6, 8'h06);
    push(INSERT_AT, 7, 8'h07);
    intf_ready = 1'b1;
    serve(6, 8'h61, 0);
    wait_issue(7);
    @(negedge clk);
    resp_vld = 1'b1;
    resp_type = DATA;
    resp_data = 8'h72;
    resp_data_vld = 1'b1;
    #1 chk("t3_blocked", resp_taken, 0);
    @(negedge clk);
    chk("t3_still_blocked", resp_taken, 0);
    chk("t3_held_vld", host_resp_vld, 1);
    chk("t3_held_data", host_resp_data, 8'h61);
    chk("t3_held_tag", host_resp_tag, 0);
    host_resp_rdy = 1'b1;
    #1 chk("t3_taken", resp_taken, 1);
    @(negedge clk);
    resp_vld = 1'b0;
    resp_data_vld = 1'b0;
    chk("t3_no_gap", host_resp_vld, 1);
    chk("t3_new_data", host_resp_data, 8'h72);
    chk("t3_new_tag", host_resp_tag, 1);
    @(negedge clk);
    chk("t3_drained", host_resp_vld, 0);

    // push during ISSUE with two entries queued
    do_reset();
    host_resp_rdy = 1'b1;
    push(ADD_TAIL, 8, 8'h08);
    push(ADD_TAIL, 9, 8'h09);
    intf_ready = 1'b1;
    wait_issue(8);
    chk("t4_issue_count", fifo_count, 2);
    push(ADD_TAIL, 10, 8'h0A);
    chk("t4_count_hold", fifo_count, 2);
    respond(8'h80, 0);
    serve(9, 8'h90, 1);
    serve(10, 8'hA5, 2);

    // reset in WAIT_RESP with three queued and a held response
    do_reset();
    for (int i = 0; i < 4; i++)
      push(DELETE_AT, PTR_WD'(11 + i), 8'(i));
    intf_ready = 1'b1;
    serve(11, 8'hB1, 0);
    push(DELETE_AT, 15, 8'h0F);
    wait_issue(12);
    @(negedge clk);
    chk("t6_count", fifo_count, 3);
    chk("t6_held", host_resp_vld, 1);
    chk("t6_busy", busy, 1);
    reset_n = 1'b1;
    #1 chk("t6_rdy_in_reset", host_req_rdy, 0);
    @(negedge clk);
    reset_n = 1'b0;
    intf_ready = 1'b0;
    #1 chk_reset("t6");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
